mcu_bus_arbiter: RTL and testbench
==================================

# mcu_bus_arbiter

Two-master arbiter for the MCU SoC memory-mapped bus. It shares the single slave-side bus (GPIO at 0x0200_0000 and other peripherals) between the CPU (master 0) and a second master such as a debug or DMA port (master 1). Ownership is granted round-robin, and a locked owner may hold the bus for a bounded run of transfers. Each transfer completes on slave ready or on a wait timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_HOLD, 4, max consecutive transfers per grant when lock is held (≥1)
- TIMEOUT, 16, cycles of s_valid without s_ready before forced error completion (≥2)

One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mN_req  in  1  master N (N=0,1) requests a transfer; held until ack
- mN_lock  in  1  request to keep ownership after this transfer
- mN_addr  in  ADDR_W  transfer address, stable while req
- mN_wdata  in  DATA_W  write data
- mN_we  in  1  1=write, 0=read
- mN_gnt  out  1  master N owns bus
- mN_ack  out  1  transfer complete (one cycle)
- mN_err  out  1  qualifies ack: timeout
- m_rdata  out  DATA_W  read data, valid with ack
- s_valid, s_addr, s_wdata, s_we  out  1/ADDR_W/DATA_W/1  slave request
- s_rdata  in  DATA_W  slave read data
- s_ready  in  1  slave completes current request
- owner  out  1  current/last owner (debug)

## Operation
- States: IDLE, XFER. Registers: state, owner, last_owner, hold_cnt, wait_cnt.
- IDLE: if exactly one req, grant it; if both, grant !last_owner. Next cycle: state=XFER, owner set, hold_cnt=0, wait_cnt=0.
- XFER behaviour:
  - mN_gnt = (state==XFER && owner==N), registered.
  - s_valid = XFER && owner's req. s_addr/s_wdata/s_we are muxed combinationally from the owner. When s_valid=0, s_* hold the owner's values.
- Completion cycle is s_valid && (s_ready || wait_cnt==TIMEOUT-1):
  - owner ack=1 combinationally.
  - If s_ready: err=0, m_rdata=s_rdata.
  - Else (timeout): err=1, m_rdata=0. s_ready wins if both occur in the same cycle.
- After a normal completion: if lock && hold_cnt<MAX_HOLD-1, stay in XFER with the same owner, hold_cnt+1, wait_cnt=0. Otherwise go to IDLE and set last_owner=owner.
- After a timeout completion: always go to IDLE, set last_owner=owner. Lock is ignored.
- Owner drops req in XFER: s_valid=0 that cycle, no ack, go to IDLE, last_owner=owner. This is abort.
- wait_cnt increments each XFER cycle with s_valid && !completion. It is saturating-safe and width $clog2(TIMEOUT).
- Non-owner req is ignored until the next IDLE.

## Timing
- Reset values: state=IDLE, owner=0, last_owner=1 (master 0 wins the first tie), all gnt/ack/err/s_valid=0, s_* data = master-0 mux, m_rdata=0, counters=0.
- Latency: req sampled high in IDLE at edge k → gnt and s_valid high from k+1. Earliest ack is in cycle k+1 if s_ready=1.
- Released bus: one IDLE bubble cycle between owners, and after every unlocked transfer.
- Locked back-to-back: the next transfer's s_valid is in the cycle after ack, with no bubble.
- Reset mid-XFER: immediate return to reset values; no ack.

## Structure
- Package mcu_bus_pkg: state enum (IDLE, XFER), default ADDR_W/DATA_W, GPIO_BASE=32'h0200_0000.
- Sub-module mcu_bus_wait_timer: wait_cnt with clear/enable/expired.
- Round-robin pick and mux stay inline.

## Test plan
- Single write: m0 req, addr 0x0200_0000, wdata 0xA5, we=1, s_ready high 1 cycle after s_valid → s_addr/s_wdata match, m0_ack at cycle k+2, m0_err=0, then IDLE.
- Tie: m0 and m1 req in the same cycle from reset → m0 granted first, then m1 after one IDLE bubble. Repeat the tie → m0 again (last_owner=1).
- Lock limit: m1 lock=1, req continuous, s_ready=1 every cycle, MAX_HOLD=4 → exactly 4 back-to-back acks. Bus then goes to waiting m0 after the bubble.
- Timeout: m0 read, s_ready stuck 0, TIMEOUT=16 → m0_ack=1, m0_err=1, m_rdata=0 on the 16th s_valid cycle, then IDLE.
- Abort: m1 drops req mid-XFER → s_valid=0 that cycle, no ack, IDLE next cycle, then m0 is granted.
- Reset: rst_n low during XFER with m0 owning → all outputs return to reset values asynchronously. After release, the first tie goes to m0.

Source files
------------

// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the MCU memory-mapped bus arbiter.
package mcu_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] GPIO_BASE = 32'h0200_0000;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } bus_state_t;

endpackage

// File: rtl/mcu_bus_wait_timer.sv
// Counts cycles a slave request has been waiting; flags the forced-error point.
module mcu_bus_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] wait_cnt;

    assign expired = (wait_cnt == CW'(TIMEOUT - 1));

    // Clear wins over counting; the count parks at its limit instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && !expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mcu_bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded lock and slave wait timeout.
module mcu_bus_arbiter
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m_rdata,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic              owner
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    bus_state_t    state;
    logic          last_owner;
    logic [HW-1:0] hold_cnt;

    logic own_req;
    logic own_lock;
    logic expired;
    logic completion;
    logic stay_locked;
    logic pick;

    // Everything on the slave side follows the current owner, even when idle.
    assign own_req  = owner ? m1_req  : m0_req;
    assign own_lock = owner ? m1_lock : m0_lock;
    assign s_addr   = owner ? m1_addr  : m0_addr;
    assign s_wdata  = owner ? m1_wdata : m0_wdata;
    assign s_we     = owner ? m1_we    : m0_we;

    assign s_valid    = (state == XFER) && own_req;
    assign completion = s_valid && (s_ready || expired);

    assign m0_ack  = completion && !owner;
    assign m1_ack  = completion &&  owner;
    assign m0_err  = m0_ack && !s_ready;
    assign m1_err  = m1_ack && !s_ready;
    assign m_rdata = (completion && s_ready) ? s_rdata : '0;

    // A timed-out transfer never keeps the bus, whatever the lock says.
    assign stay_locked = s_ready && own_lock && (int'(hold_cnt) < MAX_HOLD - 1);

    // On a tie the master that did not own the bus last time wins.
    assign pick = (m0_req && m1_req) ? !last_owner : m1_req;

    mcu_bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!s_valid || completion),
        .enable  (s_valid && !completion),
        .expired (expired)
    );

    // Ownership FSM; grants are registered alongside the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state    <= XFER;
                        owner    <= pick;
                        hold_cnt <= '0;
                        m0_gnt   <= !pick;
                        m1_gnt   <= pick;
                    end
                end
                XFER: begin
                    if (!own_req || (completion && !stay_locked)) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        m0_gnt     <= 1'b0;
                        m1_gnt     <= 1'b0;
                    end else if (completion) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Directed bench for the two-master bus arbiter.
module tb_mcu_bus_arbiter;
    import mcu_bus_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic [DATA_W-1:0] s_rdata = '0;
    logic              s_ready = 1'b0;
    logic              m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
    logic              s_valid, s_we, owner;
    logic [DATA_W-1:0] m_rdata, s_wdata;
    logic [ADDR_W-1:0] s_addr;

    // Packed view of the control outputs: gnt0 gnt1 s_valid ack0 err0 ack1 err1 owner.
    logic [7:0] st;
    assign st = {m0_gnt, m1_gnt, s_valid, m0_ack, m0_err, m1_ack, m1_err, owner};

    int vectors = 0;
    int miscompares = 0;

    mcu_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err),
        .m_rdata(m_rdata), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_rdata(s_rdata), .s_ready(s_ready), .owner(owner)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are read on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        m0_addr  = 32'h1111_0000;
        m1_addr  = 32'h2222_0000;
        m0_wdata = 32'h0000_0011;
        m1_wdata = 32'h0000_0022;
        s_rdata  = 32'hCAFE_F00D;
        repeat (2) sample();
        vectors++;
        if (st !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got %b expected %b", st, 8'h00);
        end
        vectors++;
        if (s_addr !== 32'h1111_0000 || s_wdata !== 32'h0000_0011) begin
            miscompares++;
            $display("[TB] FAIL reset_mux: got %h/%h expected %h/%h", s_addr, s_wdata, 32'h1111_0000, 32'h0000_0011);
        end
        vectors++;
        if (m_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h expected %h", m_rdata, 32'h0);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_tie();
        logic       r0 [0:8];
        logic       r1 [0:8];
        logic [7:0] exp_st [0:8];
        r0     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        r1     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_st = '{8'h00, 8'hB0, 8'h00, 8'h65, 8'h01, 8'hB0, 8'h00, 8'h65, 8'h01};
        for (int i = 0; i < 9; i++) begin
            step();
            m0_req  = r0[i];
            m1_req  = r1[i];
            s_ready = 1'b1;
            s_rdata = 32'h0000_00AA;
            sample();
            vectors++;
            if (st !== exp_st[i]) begin
                miscompares++;
                $display("[TB] FAIL tie_cycle%0d: got %b expected %b", i, st, exp_st[i]);
            end
        end
        s_ready = 1'b0;
    endtask

    task automatic test_single_write();
        step();
        m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b1;
        m0_addr = GPIO_BASE; m0_wdata = 32'h0000_00A5; s_ready = 1'b0;
        sample();
        vectors++;
        if (st !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL write_idle: got %b expected %b", st, 8'h01);
        end
        step();
        sample();
        vectors++;
        if (st !== 8'hA0) begin
            miscompares++;
            $display("[TB] FAIL write_grant: got %b expected %b", st, 8'hA0);
        end
        vectors++;
        if (s_addr !== 32'h0200_0000 || s_wdata !== 32'h0000_00A5 || s_we !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL write_slave_bus: got %h/%h/%b expected 02000000/000000a5/1", s_addr, s_wdata, s_we);
        end
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        sample();
        vectors++;
        if (st !== 8'hB0) begin
            miscompares++;
            $display("[TB] FAIL write_ack: got %b expected %b", st, 8'hB0);
        end
        vectors++;
        if (m_rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL write_rdata: got %h expected %h", m_rdata, 32'h1234_5678);
        end
        step();
        m0_req = 1'b0; s_ready = 1'b0;
        sample();
        vectors++;
        if (st !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL write_release: got %b expected %b", st, 8'h00);
        end
    endtask

    task automatic test_lock_limit();
        logic [7:0] exp_st [0:7];
        exp_st = '{8'h00, 8'h65, 8'h65, 8'h65, 8'h65, 8'h01, 8'hB0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0200_0008;
                m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0; m1_addr = 32'h0200_0010;
                s_ready = 1'b1; s_rdata = 32'h0000_5555;
            end
            if (i == 5) begin
                m1_req = 1'b0; m1_lock = 1'b0;
            end
            if (i == 7) m0_req = 1'b0;
            sample();
            vectors++;
            if (st !== exp_st[i]) begin
                miscompares++;
                $display("[TB] FAIL lock_cycle%0d: got %b expected %b", i, st, exp_st[i]);
            end
            if (i == 1) begin
                vectors++;
                if (s_addr !== 32'h0200_0010) begin
                    miscompares++;
                    $display("[TB] FAIL lock_addr: got %h expected %h", s_addr, 32'h0200_0010);
                end
            end
        end
        s_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] exp_v;
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 0) begin
                m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0200_0004;
                s_ready = 1'b0; s_rdata = 32'hFFFF_FFFF;
            end
            if (i == 17) m0_req = 1'b0;
            exp_v = (i == 0) ? 8'h00 : (i < 16) ? 8'hA0 : (i == 16) ? 8'hB8 : 8'h00;
            sample();
            vectors++;
            if (st !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL timeout_cycle%0d: got %b expected %b", i, st, exp_v);
            end
            if (i == 16) begin
                vectors++;
                if (m_rdata !== 32'h0) begin
                    miscompares++;
                    $display("[TB] FAIL timeout_rdata: got %h expected %h", m_rdata, 32'h0);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_st [0:6];
        exp_st = '{8'h00, 8'h61, 8'h41, 8'h01, 8'hA0, 8'hB0, 8'h00};
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) begin
                m0_req = 1'b1; m0_addr = 32'h0200_0030;
                m1_req = 1'b1; m1_lock = 1'b0; m1_addr = 32'h0200_0020;
                s_ready = 1'b0;
            end
            if (i == 2) m1_req = 1'b0;
            if (i == 5) begin
                s_ready = 1'b1; s_rdata = 32'h0000_0777;
            end
            if (i == 6) begin
                m0_req = 1'b0; s_ready = 1'b0;
            end
            sample();
            vectors++;
            if (st !== exp_st[i]) begin
                miscompares++;
                $display("[TB] FAIL abort_cycle%0d: got %b expected %b", i, st, exp_st[i]);
            end
            if (i == 2) begin
                vectors++;
                if (s_addr !== 32'h0200_0020) begin
                    miscompares++;
                    $display("[TB] FAIL abort_addr_hold: got %h expected %h", s_addr, 32'h0200_0020);
                end
            end
        end
    endtask

    task automatic test_reset_mid_xfer();
        step();
        m0_req = 1'b1; m0_addr = 32'h0200_0040; s_ready = 1'b0;
        sample();
        step();
        sample();
        vectors++;
        if (st !== 8'hA0) begin
            miscompares++;
            $display("[TB] FAIL rst_pre_owner: got %b expected %b", st, 8'hA0);
        end
        step();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (st !== 8'h00 || m_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got %b/%h expected %b/%h", st, m_rdata, 8'h00, 32'h0);
        end
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        rst_n = 1'b1;
        sample();
        vectors++;
        if (st !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rst_release_idle: got %b expected %b", st, 8'h00);
        end
        step();
        sample();
        vectors++;
        if (st !== 8'hA0) begin
            miscompares++;
            $display("[TB] FAIL rst_first_tie: got %b expected %b", st, 8'hA0);
        end
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        sample();
        vectors++;
        if (st !== 8'h80) begin
            miscompares++;
            $display("[TB] FAIL rst_drop_abort: got %b expected %b", st, 8'h80);
        end
        step();
        sample();
        vectors++;
        if (st !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rst_final_idle: got %b expected %b", st, 8'h00);
        end
    endtask

    // Guard against a stuck run so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_tie();
        test_single_write();
        test_lock_limit();
        test_timeout();
        test_abort();
        test_reset_mid_xfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
